// File: rtl/vedic_pkg.sv
// Shared widths, controller state encoding and partial-product shift table
// for the sequenced 8x8 Vedic multiplier.
package vedic_pkg;

    localparam int OP_W   = 8;
    localparam int HALF_W = 4;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        PP0,
        PP1,
        PP2,
        PP3,
        DONE
    } vseq_state_t;

    // Step index is {b-nibble select, a-nibble select}, so the shift is 4 per high nibble.
    function automatic logic [3:0] stepShift(input logic [1:0] step);
        logic [3:0] shiftAmt;
        case (step)
            2'd0:    shiftAmt = 4'd0;
            2'd1:    shiftAmt = 4'd4;
            2'd2:    shiftAmt = 4'd4;
            default: shiftAmt = 4'd8;
        endcase
        return shiftAmt;
    endfunction

endpackage

// File: rtl/i4bit_mul.sv
// 4x4 unsigned Vedic (Urdhva Tiryagbhyam) multiplier built from four 2x2
// vertical-and-crosswise units; purely combinational.
module i4bit_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
        logic       carry;
        logic [3:0] r;
        r[0]  = x[0] & y[0];
        r[1]  = (x[1] & y[0]) ^ (x[0] & y[1]);
        carry = (x[1] & y[0]) & (x[0] & y[1]);
        r[2]  = (x[1] & y[1]) ^ carry;
        r[3]  = (x[1] & y[1]) & carry;
        return r;
    endfunction

    logic [3:0] w_qLL;
    logic [3:0] w_qHL;
    logic [3:0] w_qLH;
    logic [3:0] w_qHH;

    assign w_qLL = mul2(a[1:0], b[1:0]);
    assign w_qHL = mul2(a[3:2], b[1:0]);
    assign w_qLH = mul2(a[1:0], b[3:2]);
    assign w_qHH = mul2(a[3:2], b[3:2]);

    // Crosswise terms share weight 4, the high vertical term weight 16.
    assign p = {4'b0000, w_qLL}
             + {2'b00, w_qHL, 2'b00}
             + {2'b00, w_qLH, 2'b00}
             + {w_qHH, 4'b0000};

endmodule

// File: rtl/vedic8_seq_ctrl.sv
// Sequenced 8x8 unsigned multiplier: one 4x4 Vedic core reused over four
// partial-product steps, with valid/ready handshakes on operands and product.
module vedic8_seq_ctrl
    import vedic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] p,
    output logic              busy
);

    vseq_state_t         r_state;
    logic [OP_W-1:0]     r_aQ;
    logic [OP_W-1:0]     r_bQ;
    logic [PROD_W-1:0]   r_acc;
    logic                r_outValid;
    logic                r_busy;

    logic [1:0]          w_step;
    logic [HALF_W-1:0]   w_coreA;
    logic [HALF_W-1:0]   w_coreB;
    logic [2*HALF_W-1:0] w_coreP;
    logic [PROD_W-1:0]   w_shifted;
    logic [PROD_W-1:0]   w_accSum;

    always_comb begin
        w_step = 2'd0;
        case (r_state)
            PP1:     w_step = 2'd1;
            PP2:     w_step = 2'd2;
            PP3:     w_step = 2'd3;
            default: w_step = 2'd0;
        endcase
    end

    assign w_coreA = w_step[0] ? r_aQ[OP_W-1:HALF_W] : r_aQ[HALF_W-1:0];
    assign w_coreB = w_step[1] ? r_bQ[OP_W-1:HALF_W] : r_bQ[HALF_W-1:0];

    i4bit_mul u_core (
        .a (w_coreA),
        .b (w_coreB),
        .p (w_coreP)
    );

    assign w_shifted = {{(PROD_W-2*HALF_W){1'b0}}, w_coreP} << stepShift(w_step);
    assign w_accSum  = r_acc + w_shifted;

    // A DONE state with out_ready high may take a new pair on the same edge.
    assign in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign out_valid = r_outValid;
    assign busy      = r_busy;
    assign p         = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_aQ       <= '0;
            r_bQ       <= '0;
            r_acc      <= '0;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_aQ    <= a;
                        r_bQ    <= b;
                        r_acc   <= '0;
                        r_state <= PP0;
                        r_busy  <= 1'b1;
                    end
                end
                PP0: begin
                    r_acc   <= w_accSum;
                    r_state <= PP1;
                end
                PP1: begin
                    r_acc   <= w_accSum;
                    r_state <= PP2;
                end
                PP2: begin
                    r_acc   <= w_accSum;
                    r_state <= PP3;
                end
                PP3: begin
                    r_acc      <= w_accSum;
                    r_state    <= DONE;
                    r_outValid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        if (in_valid) begin
                            r_aQ    <= a;
                            r_bQ    <= b;
                            r_acc   <= '0;
                            r_state <= PP0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_outValid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vedic8_seq_ctrl.md
# vedic8_seq_ctrl

Sequenced 8x8 unsigned multiplier controller that time-shares a single `i4bit_mul` 4x4 Vedic core across four partial-product steps. It accumulates the shifted partials into a 16-bit product. Operands enter and products leave through valid/ready handshakes. It is the area-reduced alternative to the fully parallel 8-bit Vedic array and sits between the TinyTapeout I/O wrapper and downstream logic.

## Interface
- Parameters: none; widths come from `vedic_pkg` (OP_W=8, HALF_W=4, PROD_W=16).
- Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand pair a/b is valid
- in_ready  out  1  controller can accept operands this cycle
- a  in  8  multiplicand, unsigned
- b  in  8  multiplier, unsigned
- out_valid  out  1  product p is valid
- out_ready  in  1  consumer accepts p this cycle
- p  out  16  product a*b, unsigned
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, PP0, PP1, PP2, PP3, DONE.
- in_ready = !rst && (IDLE || (DONE && out_ready)).
- Accept happens on an edge where in_valid && in_ready. On accept:
  - latch a into a_q and b into b_q
  - clear acc to 0
  - go to PP0
- Partial steps. The core is fed by nibble muxes from a_q/b_q. Each step adds its zero-extended 8-bit core output into acc, then advances:
  - PP0: a_q[3:0]*b_q[3:0], shift 0, then PP1
  - PP1: a_q[7:4]*b_q[3:0], shift 4, then PP2
  - PP2: a_q[3:0]*b_q[7:4], shift 4, then PP3
  - PP3: a_q[7:4]*b_q[7:4], shift 8, then DONE
- Width rule: acc is 16 bits. The maximum final value is 0xFE01, so no intermediate sum overflows and no carry-out is kept.
- DONE:
  - out_valid=1 and p=acc.
  - p and out_valid hold steady while out_ready=0.
- DONE with out_ready=1:
  - If in_valid=1: the product handshake and a new accept occur on the same edge, then go to PP0 with the new operands.
  - Otherwise go to IDLE.
- p is driven from acc at all times. It keeps the last product in IDLE and clears only on the next accept.
- in_valid in any state other than IDLE/DONE is ignored. Operands must be held by the producer until accepted.
- Reset (any state, including mid-PPx or DONE):
  - next state IDLE
  - acc, a_q, b_q cleared to 0
  - the in-flight operation is discarded, with no out_valid pulse
- Reset values: out_valid=0, p=0x0000, busy=0. in_ready=0 while rst is high and 1 in the first cycle after rst falls.

## Timing
- Latency: accept on edge E0 gives out_valid=1 in the cycle after edge E4, i.e. 4 cycles after accept.
- Throughput:
  - With a continuous in_valid and out_ready=1, one product every 5 cycles, using back-to-back accept from DONE.
  - With an idle gap, one product every 6 cycles.
- The core path (nibble mux, `i4bit_mul`, shift, 16-bit add) is single-cycle combinational into acc.
- out_valid, p and busy are registered or decoded from registered state only; there is no combinational path from in_valid or a/b.
- in_ready depends combinationally on out_ready in DONE only.

## Structure
- `vedic_pkg`:
  - state enum type `vseq_state_t` (IDLE, PP0..PP3, DONE)
  - localparams OP_W, HALF_W, PROD_W
  - a shift-amount function indexed by step
- One sub-module instance: existing `i4bit_mul` (4-bit a, 4-bit b, 8-bit product), unmodified.
- The nibble-select muxes, shifter, accumulator and FSM live in `vedic8_seq_ctrl` itself. Do not create separate adder modules.

## Test plan
- Basic: reset, then a=0x12, b=0x34, out_ready=1. Required: p=0x03A8 with out_valid exactly 4 cycles after accept, then in_ready=1 the next cycle.
- Corners:
  - a=0xFF, b=0xFF gives 0xFE01.
  - a=0x00, b=0xA5 gives 0x0000.
  - a=0x80, b=0x02 gives 0x0100.
  - a=0x0F, b=0xF0 gives 0x0E10.
- Backpressure: for a=0x0A, b=0x0B, hold out_ready=0 for 3 cycles in DONE. Required:
  - p=0x006E stable and out_valid held
  - in_ready=0 throughout
  - single handshake on release
- Back-to-back: keep in_valid=1 and out_ready=1 continuously with pairs (0x03,0x05), (0x10,0x10), (0xC8,0x02). Required:
  - products 0x000F, 0x0100, 0x0190
  - 5-cycle spacing
  - no bubble, no dropped or duplicated product
- Reset mid-operation: assert rst for 1 cycle while in PP2. Required:
  - next state IDLE, out_valid never pulses, p=0x0000
  - a following 0x07*0x09 returns 0x003F
- Random: 2000 random a/b pairs with random in_valid/out_ready stalls, checked against a scoreboard computing a*b. Required: all match, products in order.
